m26_frame_merger: RTL and testbench

- Parametrised successor of the single-plane Mimosa26 receiver core, running entirely in BUS_CLK after CDC.
- Takes NCH already-deserialised 16-bit channel streams, each with a frame-start flag, and buffers each channel independently.
- Merges the channels word by word into one 32-bit FIFO-style output using round-robin arbitration.
- Adds per-channel timestamp headers, lost-data accounting and a channel-enable mask.

---
 rtl/m26_merge_pkg.sv | 28 ++
 rtl/m26_merge_ch_buf.sv | 109 ++++++++++
 rtl/m26_frame_merger.sv | 223 ++++++++++++++++++++++
 tb/tb_m26_frame_merger.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/m26_merge_pkg.sv
// Shared constants for the Mimosa26 multi-channel frame merger: register map,
// output word type codes, merger FSM encoding and buffer entry width.
package m26_merge_pkg;

  localparam logic [7:0] VERSION = 8'd3;

  localparam int ADDR_RST   = 0;
  localparam int ADDR_CONF  = 1;
  localparam int ADDR_MASK  = 2;
  localparam int ADDR_LOST  = 3;
  localparam int ADDR_STATS = 16;

  localparam logic [7:0] CONF_RST = 8'h02;

  localparam logic [1:0] TYPE_DATA  = 2'b00;
  localparam logic [1:0] TYPE_TS_LO = 2'b01;
  localparam logic [1:0] TYPE_TS_HI = 2'b10;

  // Buffer entry: {lost, frame_start, data[15:0]}
  localparam int ENTRY_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TS_LO = 2'd1,
    ST_TS_HI = 2'd2
  } state_t;

endpackage

// File: rtl/m26_merge_ch_buf.sv
// Per-channel buffering for the frame merger: data FIFO, timestamp queue,
// lost-word accounting. Optional macro M26_MERGE_STATS_EN adds a wrapping
// count of accepted frame starts.
module m26_merge_ch_buf
  import m26_merge_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int TSQ   = 4
) (
  input  logic               clk_i,
  input  logic               irst_i,
  input  logic               wr_i,
  input  logic               fs_i,
  input  logic [15:0]        data_i,
  input  logic [31:0]        ts_i,
  input  logic               pop_i,
  input  logic               ts_pop_i,
  output logic               empty_o,
  output logic [ENTRY_W-1:0] head_o,
  output logic [31:0]        ts_head_o,
  output logic [7:0]         lost_cnt_o
`ifdef M26_MERGE_STATS_EN
  ,
  output logic [15:0]        fs_cnt_o
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TSQ > 1) ? $clog2(TSQ) : 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [31:0]        ts_mem_q [TSQ];
  logic [AW-1:0]      wp_q, rp_q;
  logic [AW:0]        cnt_q;
  logic [TW-1:0]      twp_q, trp_q;
  logic [TW:0]        tcnt_q;
  logic               lost_pend_q;
  logic [7:0]         lost_cnt_q;

  logic full, ts_full, accept, reject, ts_push, do_pop, do_tpop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign ts_full = (tcnt_q == (TW+1)'(TSQ));
  assign accept  = wr_i && !full && (!fs_i || !ts_full);
  assign reject  = wr_i && !accept;
  assign ts_push = accept && fs_i;
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_tpop = ts_pop_i && (tcnt_q != '0);

  // Control state: pointers, occupancy, lost tracking
  always_ff @(posedge clk_i) begin
    if (irst_i) begin
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      twp_q       <= '0;
      trp_q       <= '0;
      tcnt_q      <= '0;
      lost_pend_q <= 1'b0;
      lost_cnt_q  <= '0;
    end else begin
      if (accept) wp_q <= wp_q + 1'b1;
      if (do_pop) rp_q <= rp_q + 1'b1;
      case ({accept, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      // TS queue depth may be 1, so wrap explicitly
      if (ts_push) twp_q <= (twp_q == TW'(TSQ-1)) ? '0 : twp_q + 1'b1;
      if (do_tpop) trp_q <= (trp_q == TW'(TSQ-1)) ? '0 : trp_q + 1'b1;
      case ({ts_push, do_tpop})
        2'b10:   tcnt_q <= tcnt_q + 1'b1;
        2'b01:   tcnt_q <= tcnt_q - 1'b1;
        default: tcnt_q <= tcnt_q;
      endcase
      if (reject) begin
        lost_pend_q <= 1'b1;
        if (lost_cnt_q != 8'hFF) lost_cnt_q <= lost_cnt_q + 8'd1;
      end else if (accept) begin
        lost_pend_q <= 1'b0;
      end
    end
  end

  // Storage arrays, written on acceptance only
  always_ff @(posedge clk_i) begin
    if (accept)  mem_q[wp_q]     <= {lost_pend_q, fs_i, data_i};
    if (ts_push) ts_mem_q[twp_q] <= ts_i;
  end

  assign empty_o    = (cnt_q == '0);
  assign head_o     = mem_q[rp_q];
  assign ts_head_o  = ts_mem_q[trp_q];
  assign lost_cnt_o = lost_cnt_q;

`ifdef M26_MERGE_STATS_EN
  logic [15:0] fs_cnt_q;

  // Wrapping count of accepted frame starts
  always_ff @(posedge clk_i) begin
    if (irst_i)       fs_cnt_q <= '0;
    else if (ts_push) fs_cnt_q <= fs_cnt_q + 16'd1;
  end

  assign fs_cnt_o = fs_cnt_q;
`endif

endmodule

// File: rtl/m26_frame_merger.sv
// Mimosa26 frame merger: NCH buffered 16-bit channel streams merged
// round-robin into a 32-bit first-word-fall-through output with optional
// timestamp headers, lost-word accounting and a channel mask.
// Optional macro M26_MERGE_STATS_EN: per-channel frame-start counters.
module m26_frame_merger
  import m26_merge_pkg::*;
#(
  parameter int         NCH        = 4,
  parameter int         DEPTH      = 64,
  parameter int         TSQ        = 4,
  parameter int         ABUSWIDTH  = 16,
  parameter logic [7:0] HEADER     = 8'h00,
  parameter int         IDENT_BASE = 0
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic [NCH-1:0]       CH_WRITE,
  input  logic [NCH-1:0]       CH_FRAME_START,
  input  logic [16*NCH-1:0]    CH_DATA,
  input  logic [31:0]          TIMESTAMP,
  input  logic                 FIFO_READ,
  output logic                 FIFO_EMPTY,
  output logic [31:0]          FIFO_DATA,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 BUS_WR,
  input  logic                 BUS_RD,
  output logic                 LOST_ERROR
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  function automatic logic [3:0] chan_id(input logic [CW-1:0] ch);
    return 4'(IDENT_BASE + int'(ch));
  endfunction

  logic               irst;
  logic [7:0]         conf_q;
  logic [NCH-1:0]     mask_q;
  logic [NCH-1:0]     ch_empty, ch_pop, ch_tpop;
  logic [ENTRY_W-1:0] ch_head [NCH];
  logic [31:0]        ch_ts [NCH];
  logic [7:0]         lost_cnt [NCH];
`ifdef M26_MERGE_STATS_EN
  logic [15:0]        fs_cnt [NCH];
  logic [7:0]         shadow_q;
`endif

  state_t             state_q, state_d;
  logic [CW-1:0]      last_grant_q, last_grant_d, cur_ch_q, cur_ch_d;
  logic [CW-1:0]      grant, sel;
  logic               grant_vld, can_load, ld;
  logic [ENTRY_W-1:0] head;
  logic [31:0]        ts;
  logic [31:0]        word_d, out_data_q;
  logic               out_vld_q;
  logic [7:0]         rd_d, rd_q;

  assign irst = RST || (BUS_WR && (BUS_ADD == ABUSWIDTH'(ADDR_RST)));

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    m26_merge_ch_buf #(.DEPTH(DEPTH), .TSQ(TSQ)) u_buf (
      .clk_i      (BUS_CLK),
      .irst_i     (irst),
      .wr_i       (CH_WRITE[c] && conf_q[0] && mask_q[c]),
      .fs_i       (CH_FRAME_START[c]),
      .data_i     (CH_DATA[16*c +: 16]),
      .ts_i       (TIMESTAMP),
      .pop_i      (ch_pop[c]),
      .ts_pop_i   (ch_tpop[c]),
      .empty_o    (ch_empty[c]),
      .head_o     (ch_head[c]),
      .ts_head_o  (ch_ts[c]),
      .lost_cnt_o (lost_cnt[c])
`ifdef M26_MERGE_STATS_EN
      ,
      .fs_cnt_o   (fs_cnt[c])
`endif
    );
  end

  // Round-robin pick: first non-empty channel after the last grant
  always_comb begin
    int idx;
    idx       = 0;
    grant     = last_grant_q;
    grant_vld = 1'b0;
    for (int i = NCH; i >= 1; i--) begin
      idx = (int'(last_grant_q) + i) % NCH;
      if (!ch_empty[idx]) begin
        grant     = CW'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  assign can_load = !out_vld_q || FIFO_READ;

  // Merger FSM next state, output word build and buffer pops
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_ch_d     = cur_ch_q;
    ld           = 1'b0;
    word_d       = '0;
    ch_pop       = '0;
    ch_tpop      = '0;
    sel          = (state_q == ST_IDLE) ? grant : cur_ch_q;
    head         = ch_head[sel];
    ts           = ch_ts[sel];
    if (can_load) begin
      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            ld           = 1'b1;
            last_grant_d = grant;
            cur_ch_d     = grant;
            if (head[16] && conf_q[1]) begin
              word_d  = {HEADER, chan_id(grant), TYPE_TS_LO, 2'b00, ts[15:0]};
              state_d = ST_TS_LO;
            end else begin
              word_d         = {HEADER, chan_id(grant), TYPE_DATA, head};
              ch_pop[grant]  = 1'b1;
              ch_tpop[grant] = head[16];
            end
          end
        end
        ST_TS_LO: begin
          ld      = 1'b1;
          word_d  = {HEADER, chan_id(cur_ch_q), TYPE_TS_HI, 2'b00, ts[31:16]};
          state_d = ST_TS_HI;
        end
        ST_TS_HI: begin
          ld                = 1'b1;
          word_d            = {HEADER, chan_id(cur_ch_q), TYPE_DATA, head};
          ch_pop[cur_ch_q]  = 1'b1;
          ch_tpop[cur_ch_q] = 1'b1;
          state_d           = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM, arbitration and output-stage registers
  always_ff @(posedge BUS_CLK) begin
    if (irst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= CW'(NCH-1);
      cur_ch_q     <= '0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_ch_q     <= cur_ch_d;
      if (ld) begin
        out_vld_q  <= 1'b1;
        out_data_q <= word_d;
      end else if (FIFO_READ) begin
        out_vld_q  <= 1'b0;
      end
    end
  end

  assign FIFO_EMPTY = !out_vld_q;
  assign FIFO_DATA  = out_data_q;

  // Configuration registers survive the soft reset
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      conf_q <= CONF_RST;
      mask_q <= '1;
    end else if (BUS_WR) begin
      if (BUS_ADD == ABUSWIDTH'(ADDR_CONF))      conf_q <= BUS_DATA_IN;
      else if (BUS_ADD == ABUSWIDTH'(ADDR_MASK)) mask_q <= BUS_DATA_IN[NCH-1:0];
    end
  end

  // Register read mux
  always_comb begin
    rd_d = 8'h00;
    if (BUS_ADD == ABUSWIDTH'(ADDR_RST))       rd_d = VERSION;
    else if (BUS_ADD == ABUSWIDTH'(ADDR_CONF)) rd_d = conf_q;
    else if (BUS_ADD == ABUSWIDTH'(ADDR_MASK)) rd_d = 8'(mask_q);
    for (int k = 0; k < NCH; k++) begin
      if (BUS_ADD == ABUSWIDTH'(ADDR_LOST + k)) rd_d = lost_cnt[k];
`ifdef M26_MERGE_STATS_EN
      if (BUS_ADD == ABUSWIDTH'(ADDR_STATS + 2*k))     rd_d = fs_cnt[k][7:0];
      if (BUS_ADD == ABUSWIDTH'(ADDR_STATS + 2*k + 1)) rd_d = shadow_q;
`endif
    end
  end

  // Registered read data
  always_ff @(posedge BUS_CLK) begin
    if (irst)        rd_q <= '0;
    else if (BUS_RD) rd_q <= rd_d;
  end

  assign BUS_DATA_OUT = rd_q;

`ifdef M26_MERGE_STATS_EN
  // Low-byte read captures the matching high byte for a coherent 16-bit read
  always_ff @(posedge BUS_CLK) begin
    if (irst) begin
      shadow_q <= '0;
    end else if (BUS_RD) begin
      for (int k = 0; k < NCH; k++)
        if (BUS_ADD == ABUSWIDTH'(ADDR_STATS + 2*k)) shadow_q <= fs_cnt[k][15:8];
    end
  end
`endif

  // Any channel that has dropped words raises the error flag
  always_comb begin
    LOST_ERROR = 1'b0;
    for (int k = 0; k < NCH; k++)
      if (lost_cnt[k] != 8'h00) LOST_ERROR = 1'b1;
  end

endmodule

// File: tb/tb_m26_frame_merger.sv
// Directed self-checking bench for m26_frame_merger (NCH=4, DEPTH=64).
module tb_m26_frame_merger;

  logic        BUS_CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  CH_WRITE = '0;
  logic [3:0]  CH_FRAME_START = '0;
  logic [63:0] CH_DATA = '0;
  logic [31:0] TIMESTAMP = '0;
  logic        FIFO_READ = 1'b0;
  logic        FIFO_EMPTY;
  logic [31:0] FIFO_DATA;
  logic [15:0] BUS_ADD = '0;
  logic [7:0]  BUS_DATA_IN = '0;
  logic [7:0]  BUS_DATA_OUT;
  logic        BUS_WR = 1'b0;
  logic        BUS_RD = 1'b0;
  logic        LOST_ERROR;

  int checks = 0;
  int errors = 0;

  m26_frame_merger #(
    .NCH(4), .DEPTH(64), .TSQ(4), .ABUSWIDTH(16), .HEADER(8'h00), .IDENT_BASE(0)
  ) dut (
    .BUS_CLK        (BUS_CLK),
    .RST            (RST),
    .CH_WRITE       (CH_WRITE),
    .CH_FRAME_START (CH_FRAME_START),
    .CH_DATA        (CH_DATA),
    .TIMESTAMP      (TIMESTAMP),
    .FIFO_READ      (FIFO_READ),
    .FIFO_EMPTY     (FIFO_EMPTY),
    .FIFO_DATA      (FIFO_DATA),
    .BUS_ADD        (BUS_ADD),
    .BUS_DATA_IN    (BUS_DATA_IN),
    .BUS_DATA_OUT   (BUS_DATA_OUT),
    .BUS_WR         (BUS_WR),
    .BUS_RD         (BUS_RD),
    .LOST_ERROR     (LOST_ERROR)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  task automatic tick();
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    BUS_ADD = addr;
    BUS_DATA_IN = data;
    BUS_WR = 1'b1;
    tick();
    BUS_WR = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [7:0] data);
    BUS_ADD = addr;
    BUS_RD = 1'b1;
    tick();
    BUS_RD = 1'b0;
    data = BUS_DATA_OUT;
  endtask

  // {empty, data} packed for one-shot output checks
  function automatic logic [39:0] outw(input logic empty, input logic [31:0] data);
    return {7'h0, empty, data};
  endfunction

  initial begin
    logic [7:0] rd;
    int n;

    // Reset
    repeat (3) tick();
    RST = 1'b0;
    check("rst_out", outw(FIFO_EMPTY, FIFO_DATA), outw(1'b1, 32'h0));
    check("rst_busout", 40'(BUS_DATA_OUT), 40'h0);
    check("rst_lost_err", 40'(LOST_ERROR), 40'h0);
    bus_read(16'd0, rd); check("rd_version", 40'(rd), 40'h03);
    bus_read(16'd1, rd); check("rd_conf", 40'(rd), 40'h02);
    bus_read(16'd2, rd); check("rd_mask", 40'(rd), 40'h0F);
    bus_read(16'd4, rd); check("rd_lost1", 40'(rd), 40'h00);
    bus_read(16'd9, rd); check("rd_unmapped", 40'(rd), 40'h00);

    // Frame start with timestamp header on channel 1
    bus_write(16'd1, 8'h03);
    FIFO_READ = 1'b1;
    TIMESTAMP = 32'h12345678;
    CH_WRITE = 4'b0010; CH_FRAME_START = 4'b0010; CH_DATA[31:16] = 16'hAAAA;
    tick();
    CH_WRITE = '0; CH_FRAME_START = '0; TIMESTAMP = 32'hDEADBEEF;
    check("hdr_lat1", outw(FIFO_EMPTY, 32'h0), outw(1'b1, 32'h0));
    tick(); check("hdr_ts_lo", outw(FIFO_EMPTY, FIFO_DATA), outw(1'b0, 32'h00145678));
    tick(); check("hdr_ts_hi", outw(FIFO_EMPTY, FIFO_DATA), outw(1'b0, 32'h00181234));
    tick(); check("hdr_data", outw(FIFO_EMPTY, FIFO_DATA), outw(1'b0, 32'h0011AAAA));
    tick(); check("hdr_drained", outw(FIFO_EMPTY, 32'h0), outw(1'b1, 32'h0));

    // No header: plain word on ch2, frame start on ch3
    bus_write(16'd1, 8'h01);
    CH_WRITE = 4'b0100; CH_DATA[47:32] = 16'h1234;
    tick();
    CH_WRITE = '0;
    check("nohdr_lat1", outw(FIFO_EMPTY, 32'h0), outw(1'b1, 32'h0));
    tick(); check("nohdr_data", outw(FIFO_EMPTY, FIFO_DATA), outw(1'b0, 32'h00201234));
    CH_WRITE = 4'b1000; CH_FRAME_START = 4'b1000; CH_DATA[63:48] = 16'hBEEF;
    tick();
    CH_WRITE = '0; CH_FRAME_START = '0;
    tick(); check("nohdr_fs", outw(FIFO_EMPTY, FIFO_DATA), outw(1'b0, 32'h0031BEEF));
    tick(); check("nohdr_drained", outw(FIFO_EMPTY, 32'h0), outw(1'b1, 32'h0));

    // All four channels every cycle for 8 cycles: gapless round robin
    for (int t = 0; t <= 32; t++) begin
      if (t < 8) begin
        CH_WRITE = 4'hF;
        for (int c = 0; c < 4; c++) CH_DATA[16*c +: 16] = 16'((c << 8) | t);
      end else begin
        CH_WRITE = '0;
      end
      tick();
      if (t >= 1) begin
        n = t - 1;
        check("rr_word", outw(FIFO_EMPTY, FIFO_DATA),
              outw(1'b0, {8'h00, 4'(n % 4), 4'h0, 16'(((n % 4) << 8) | (n / 4))}));
      end
    end
    tick(); check("rr_drained", outw(FIFO_EMPTY, 32'h0), outw(1'b1, 32'h0));
    bus_read(16'd3, rd); check("rr_no_loss", 40'(rd), 40'h00);

    // Overflow: output stage holds one word, ch0 sends DEPTH+3 words
    FIFO_READ = 1'b0;
    CH_WRITE = 4'b0010; CH_DATA[31:16] = 16'h0101;
    tick();
    CH_WRITE = '0;
    tick();
    for (int i = 0; i < 67; i++) begin
      CH_WRITE = 4'b0001; CH_DATA[15:0] = 16'(i);
      tick();
    end
    CH_WRITE = '0;
    bus_read(16'd3, rd); check("lost_cnt0", 40'(rd), 40'h03);
    check("lost_error", 40'(LOST_ERROR), 40'h1);
    bus_read(16'd4, rd); check("lost_cnt1", 40'(rd), 40'h00);
    check("ovf_held", outw(FIFO_EMPTY, FIFO_DATA), outw(1'b0, 32'h00100101));
    FIFO_READ = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      check("ovf_drain", outw(FIFO_EMPTY, FIFO_DATA), outw(1'b0, 32'(i)));
    end
    tick(); check("ovf_drained", outw(FIFO_EMPTY, 32'h0), outw(1'b1, 32'h0));
    CH_WRITE = 4'b0001; CH_DATA[15:0] = 16'h5555;
    tick();
    CH_WRITE = '0;
    tick(); check("lost_flag", outw(FIFO_EMPTY, FIFO_DATA), outw(1'b0, 32'h00025555));
    CH_WRITE = 4'b0001; CH_DATA[15:0] = 16'h6666;
    tick();
    CH_WRITE = '0;
    tick(); check("lost_flag_clr", outw(FIFO_EMPTY, FIFO_DATA), outw(1'b0, 32'h00006666));
    tick();

    // Masked channel 1: nothing accepted, nothing counted
    bus_write(16'd2, 8'h0D);
    CH_WRITE = 4'b0010; CH_DATA[31:16] = 16'h7777;
    repeat (3) tick();
    CH_WRITE = '0;
    repeat (2) tick();
    check("mask_empty", outw(FIFO_EMPTY, 32'h0), outw(1'b1, 32'h0));
    bus_read(16'd4, rd); check("mask_lost1", 40'(rd), 40'h00);

    // Soft reset via address 0 while ch0 is streaming
    FIFO_READ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      CH_WRITE = 4'b0001; CH_DATA[15:0] = 16'(16'h1000 + i);
      tick();
    end
    check("pre_srst", outw(FIFO_EMPTY, FIFO_DATA), outw(1'b0, 32'h00001000));
    bus_write(16'd0, 8'h00);
    check("srst_out", outw(FIFO_EMPTY, FIFO_DATA), outw(1'b1, 32'h0));
    check("srst_lost_err", 40'(LOST_ERROR), 40'h0);
    CH_WRITE = '0;
    repeat (2) tick();
    check("srst_bufs_clear", outw(FIFO_EMPTY, 32'h0), outw(1'b1, 32'h0));
    bus_read(16'd3, rd); check("srst_lost0", 40'(rd), 40'h00);

`ifdef M26_MERGE_STATS_EN
    // 300 frame starts on ch2 -> counter 0x012C
    bus_write(16'd2, 8'h0F);
    bus_write(16'd1, 8'h01);
    FIFO_READ = 1'b1;
    for (int i = 0; i < 300; i++) begin
      CH_WRITE = 4'b0100; CH_FRAME_START = 4'b0100; CH_DATA[47:32] = 16'(i);
      tick();
    end
    CH_WRITE = '0; CH_FRAME_START = '0;
    repeat (4) tick();
    bus_read(16'd20, rd); check("stats_lo", 40'(rd), 40'h2C);
    bus_read(16'd21, rd); check("stats_hi", 40'(rd), 40'h01);
    bus_read(16'd5, rd);  check("stats_lost2", 40'(rd), 40'h00);
`else
    bus_read(16'd20, rd); check("stats_absent", 40'(rd), 40'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
